// File: rtl/inv_sub_bytes_serial.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_serial
//
// Inverse SubBytes stage of an AES decryption round. A 128-bit state from the
// inverse ShiftRows stage is captured, then every byte is replaced in place by
// its inverse S-box value. LANES bytes are substituted per cycle, so the whole
// block takes NCYC = 16/LANES cycles. The inverse S-box is computed
// arithmetically: inverse affine transform, then t^254 in GF(2^8).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream offers in_state
//   in_ready   block can accept a state (IDLE only)
//   in_state   128-bit input state, byte i = bits [8i+7:8i]
//   out_valid  out_state holds a completed result (DONE only)
//   out_ready  downstream accepts out_state
//   out_state  substituted state, same byte ordering as in_state
//   busy       high while a block is in RUN or DONE
// -----------------------------------------------------------------------------
module inv_sub_bytes_serial #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  // Reject lane counts that do not divide the block into equal byte groups.
  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [127:0]    data_q, data_nxt;
  logic [CW-1:0]   cnt;
  logic            load, step, last;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial 0x11B.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    // NOTE: inside functions and always_comb, blocking '=' is correct: each
    // statement must see the value produced by the one before it.
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // t^254 = t^-1 for t != 0, and 0 for t = 0, via a square/multiply chain.
  function automatic logic [7:0] gf_inv(input logic [7:0] t);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(t, t), t);
    x7   = gf_mul(gf_mul(x3, x3), t);
    x15  = gf_mul(gf_mul(x7, x7), t);
    x31  = gf_mul(gf_mul(x15, x15), t);
    x63  = gf_mul(gf_mul(x31, x31), t);
    x127 = gf_mul(gf_mul(x63, x63), t);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
    return gf_inv(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign last = (cnt == CW'(NCYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: LANES substitution units work on byte group cnt.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_nxt = data_q;
    for (int l = 0; l < LANES; l++) begin
      int idx;
      idx = int'(cnt) * LANES + l;
      data_nxt[idx*8 +: 8] = inv_sbox(data_q[idx*8 +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // the pre-edge values, independent of statement order.
      data_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      data_q <= in_state;
      cnt    <= '0;
    end else if (step) begin
      data_q <= data_nxt;
      cnt    <= last ? '0 : cnt + CW'(1);
    end
  end

  assign out_state = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_bytes_serial
//
// Drives three instances of inv_sub_bytes_serial (LANES = 1, 4, 16) from one
// clock and reset. Expected values come from constant vectors and from an
// inverse S-box table built by inverting the forward AES S-box, which is
// itself derived by brute-force search for multiplicative inverses.
// -----------------------------------------------------------------------------
module tb_inv_sub_bytes_serial;

  localparam int ND = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [ND-1:0]         in_valid  = '0;
  logic [ND-1:0]         in_ready;
  logic [ND-1:0][127:0]  in_state  = '0;
  logic [ND-1:0]         out_valid;
  logic [ND-1:0]         out_ready = '0;
  logic [ND-1:0][127:0]  out_state;
  logic [ND-1:0]         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_inv [256];
  int         ncyc_of [ND] = '{16, 4, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LN = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    inv_sub_bytes_serial #(.LANES(LN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int acc, aa;
    acc = 0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) acc = acc ^ aa;
      aa = aa << 1;
      if (aa >= 256) aa = aa ^ 'h11B;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_ref();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, y, s;
      xb = 8'(x);
      y  = 8'h00;
      for (int c = 1; c < 256; c++)
        if (m_mul(xb, 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ m_rotl(y, 1) ^ m_rotl(y, 2) ^ m_rotl(y, 3) ^ m_rotl(y, 4) ^ 8'h63;
      ref_inv[s] = xb;
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_inv[s[i*8 +: 8]];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enters and leaves at a falling edge. Sends one block to DUT d, measures
  // the acceptance-to-out_valid latency in clock edges, checks the result and
  // the return to IDLE after the output handshake.
  task automatic run_block(input int d, input logic [127:0] blk,
                           input logic [127:0] exp, input string name);
    int w, lat;
    w = 0;
    while (!in_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready"}, 128'(in_ready[d]), 128'd1);
    if (!in_ready[d]) return;
    in_state[d] = blk;
    in_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(ncyc_of[d]));
    check({name, "_data"}, out_state[d], exp);
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({name, "_idle"}, {126'd0, out_valid[d], in_ready[d]}, 128'd1);
  endtask

  // in_valid and out_ready both held high; checks acceptance spacing and
  // in-order, loss-free delivery.
  task automatic back_to_back(input int d, input int nblk);
    logic [127:0] blks [$];
    logic [127:0] exp_q [$];
    int idx, got, cyc, last_acc;
    logic acc, ov;
    logic [127:0] os;
    for (int i = 0; i < nblk; i++)
      blks.push_back({$urandom, $urandom, $urandom, $urandom});
    idx = 0; got = 0; cyc = 0; last_acc = 0;
    in_state[d]  = blks[0];
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b1;
    while (got < nblk && cyc < 1000) begin
      acc = in_valid[d] && in_ready[d];
      ov  = out_valid[d];
      os  = out_state[d];
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(ref_block(blks[idx]));
        if (idx > 0)
          check($sformatf("b2b%0d_interval%0d", d, idx), 128'(cyc - last_acc),
                128'(ncyc_of[d] + 2));
        last_acc = cyc;
        idx++;
      end
      if (ov) begin
        if (exp_q.size() == 0) check($sformatf("b2b%0d_spurious", d), 128'd1, 128'd0);
        else check($sformatf("b2b%0d_out%0d", d, got), os, exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
      if (idx < nblk) in_state[d] = blks[idx];
      else            in_valid[d] = 1'b0;
    end
    check($sformatf("b2b%0d_count", d), 128'(got), 128'(nblk));
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int           dut;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [127:0] ord_in, ord_out, snap, blk;
    int w;

    vecs[0] = '{0, {16{8'h63}}, {16{8'h00}}};
    vecs[1] = '{0, {16{8'h00}}, {16{8'h52}}};
    ord_in  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    ord_out = 128'h0f0e0d0c0b0a09080706050403020100;
    vecs[2] = '{0, ord_in, ord_out};
    vecs[3] = '{1, ord_in, ord_out};
    vecs[4] = '{2, ord_in, ord_out};
    // bytes 16, ED, 7C, 63 -> FF, 53, 01, 00
    vecs[5] = '{1, {4{32'h637ced16}}, {4{32'h000153ff}}};
    vecs[6] = '{2, {4{32'h637ced16}}, {4{32'h000153ff}}};

    build_ref();

    // Reset state
    #1;
    for (int d = 0; d < ND; d++)
      check($sformatf("reset%0d", d),
            {out_state[d][124:0], out_valid[d], busy[d], 1'b0}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      check($sformatf("ready_after_reset%0d", d), 128'(in_ready[d]), 128'd1);

    // Known vectors
    for (int i = 0; i < 7; i++)
      run_block(vecs[i].dut, vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));

    // All 256 byte values through the LANES=1 instance
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) blk[i*8 +: 8] = 8'(b * 16 + i);
      run_block(0, blk, ref_block(blk), $sformatf("exh%0d", b));
    end

    // Random blocks across all lane counts
    for (int r = 0; r < 12; r++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_block(r % ND, blk, ref_block(blk), $sformatf("rnd%0d", r));
    end

    // Backpressure in DONE
    blk = {$urandom, $urandom, $urandom, $urandom};
    in_state[0] = blk;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    w = 0;
    while (!out_valid[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_reach_done", 128'(out_valid[0]), 128'd1);
    snap = out_state[0];
    check("bp_data", snap, ref_block(blk));
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = k[0];
      in_state[0] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), out_state[0], snap);
      check($sformatf("bp_flags%0d", k), {125'd0, out_valid[0], in_ready[0], busy[0]}, 128'b101);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_release", {125'd0, out_valid[0], in_ready[0], busy[0]}, 128'b010);

    // Reset in the middle of RUN
    in_state[0] = {16{8'h00}};
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 128'(busy[0]), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset", {out_state[0][125:0], out_valid[0], busy[0]}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_ready", 128'(in_ready[0]), 128'd1);
    check("mid_no_valid", 128'(out_valid[0]), 128'd0);
    run_block(0, ord_in, ord_out, "post_reset");

    // Back-to-back streaming
    back_to_back(0, 4);
    back_to_back(1, 5);
    back_to_back(2, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
